// File: rtl/decode_modrm_fsm.sv
// ModR/M + SIB + displacement walker: one instruction byte per beat in, one effective-address descriptor out.
// Latency: descriptor valid length+1 edges after start is accepted (one edge per consumed byte).
// Backpressure: byte_valid gaps stall in place; out_valid holds the descriptor until out_ready; flush aborts to IDLE.
module decode_modrm_fsm #(
    parameter bit ENABLE_ADDR32 = 1'b1,
    parameter int DISP_WIDTH    = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  addr32,
    output logic                  start_ready,
    input  logic                  flush,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            mod,
    output logic [2:0]            reg_field,
    output logic [2:0]            rm,
    output logic                  reg_operand,
    output logic                  base_valid,
    output logic [2:0]            base,
    output logic                  index_valid,
    output logic [2:0]            index,
    output logic [1:0]            scale,
    output logic [DISP_WIDTH-1:0] disp,
    output logic                  seg_ss,
    output logic [2:0]            length
);

    typedef enum logic [2:0] {S_IDLE, S_MODRM, S_SIB, S_DISP, S_DONE} state_t;

    state_t      state;
    logic        a32_q;
    logic [1:0]  cnt_q;
    logic [1:0]  len_m1_q;
    logic [31:0] disp_q;

    // {needed, byte count - 1}; 'direct' marks the mod==00 no-base encodings that still carry a displacement
    function automatic logic [2:0] disp_info(input logic [1:0] m, input logic a32, input logic direct);
        case (m)
            2'b01:   return {1'b1, 2'd0};
            2'b10:   return {1'b1, a32 ? 2'd3 : 2'd1};
            2'b00:   return direct ? {1'b1, a32 ? 2'd3 : 2'd1} : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    logic [1:0]  b_mod;
    logic [2:0]  b_hi;
    logic [2:0]  b_lo;
    logic        m_base_v;
    logic [2:0]  m_base;
    logic        m_idx_v;
    logic [2:0]  m_idx;
    logic        s_base_v;
    logic [2:0]  m_disp;
    logic [2:0]  s_disp;
    logic [31:0] acc_nxt;
    logic [31:0] acc_sext;
    logic        start_go;

    assign b_mod = byte_data[7:6];
    assign b_hi  = byte_data[5:3];
    assign b_lo  = byte_data[2:0];

    assign byte_ready  = (state == S_MODRM) || (state == S_SIB) || (state == S_DISP);
    assign start_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign start_go    = start && start_ready;
    assign disp        = disp_q[DISP_WIDTH-1:0];

    // Non-SIB base/index from the ModR/M byte, already mapped to 32-bit register numbers
    always_comb begin
        m_base_v = 1'b1;
        m_base   = 3'd0;
        m_idx_v  = 1'b0;
        m_idx    = 3'd0;
        if (a32_q) begin
            m_base_v = !(b_lo == 3'd5 && b_mod == 2'b00);
            m_base   = m_base_v ? b_lo : 3'd0;
        end else begin
            case (b_lo)
                3'd0:    begin m_base = 3'd3; m_idx_v = 1'b1; m_idx = 3'd6; end
                3'd1:    begin m_base = 3'd3; m_idx_v = 1'b1; m_idx = 3'd7; end
                3'd2:    begin m_base = 3'd5; m_idx_v = 1'b1; m_idx = 3'd6; end
                3'd3:    begin m_base = 3'd5; m_idx_v = 1'b1; m_idx = 3'd7; end
                3'd4:    m_base = 3'd6;
                3'd5:    m_base = 3'd7;
                3'd6:    begin
                    m_base_v = (b_mod != 2'b00);
                    m_base   = m_base_v ? 3'd5 : 3'd0;
                end
                default: m_base = 3'd3;
            endcase
        end
    end

    assign s_base_v = !(b_lo == 3'd5 && mod == 2'b00);
    assign m_disp   = disp_info(b_mod, a32_q, a32_q ? (b_lo == 3'd5) : (b_lo == 3'd6));
    assign s_disp   = disp_info(mod, 1'b1, b_lo == 3'd5);

    assign acc_nxt = disp_q | ({24'd0, byte_data} << {cnt_q, 3'b000});

    always_comb begin
        case (len_m1_q)
            2'd0:    acc_sext = {{24{acc_nxt[7]}}, acc_nxt[7:0]};
            2'd1:    acc_sext = {{16{acc_nxt[15]}}, acc_nxt[15:0]};
            default: acc_sext = acc_nxt;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            a32_q       <= 1'b0;
            cnt_q       <= 2'd0;
            len_m1_q    <= 2'd0;
            disp_q      <= 32'd0;
            out_valid   <= 1'b0;
            mod         <= 2'd0;
            reg_field   <= 3'd0;
            rm          <= 3'd0;
            reg_operand <= 1'b0;
            base_valid  <= 1'b0;
            base        <= 3'd0;
            index_valid <= 1'b0;
            index       <= 3'd0;
            scale       <= 2'd0;
            seg_ss      <= 1'b0;
            length      <= 3'd0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else if (start_go) begin
            // New decode starts from a clean descriptor so untouched fields read as 0
            state       <= S_MODRM;
            a32_q       <= ENABLE_ADDR32 && addr32;
            cnt_q       <= 2'd0;
            len_m1_q    <= 2'd0;
            disp_q      <= 32'd0;
            out_valid   <= 1'b0;
            mod         <= 2'd0;
            reg_field   <= 3'd0;
            rm          <= 3'd0;
            reg_operand <= 1'b0;
            base_valid  <= 1'b0;
            base        <= 3'd0;
            index_valid <= 1'b0;
            index       <= 3'd0;
            scale       <= 2'd0;
            seg_ss      <= 1'b0;
            length      <= 3'd0;
        end else begin
            case (state)
                S_MODRM: if (byte_valid) begin
                    mod       <= b_mod;
                    reg_field <= b_hi;
                    rm        <= b_lo;
                    length    <= 3'd1;
                    if (b_mod == 2'b11) begin
                        reg_operand <= 1'b1;
                        state       <= S_DONE;
                        out_valid   <= 1'b1;
                    end else if (a32_q && b_lo == 3'd4) begin
                        state <= S_SIB;
                    end else begin
                        base_valid  <= m_base_v;
                        base        <= m_base;
                        index_valid <= m_idx_v;
                        index       <= m_idx;
                        seg_ss      <= m_base_v && (m_base[2:1] == 2'b10);
                        cnt_q       <= 2'd0;
                        len_m1_q    <= m_disp[1:0];
                        if (m_disp[2]) begin
                            state <= S_DISP;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_SIB: if (byte_valid) begin
                    scale       <= byte_data[7:6];
                    index       <= b_hi;
                    index_valid <= (b_hi != 3'd4);
                    base        <= b_lo;
                    base_valid  <= s_base_v;
                    seg_ss      <= s_base_v && (b_lo[2:1] == 2'b10);
                    length      <= length + 3'd1;
                    cnt_q       <= 2'd0;
                    len_m1_q    <= s_disp[1:0];
                    if (s_disp[2]) begin
                        state <= S_DISP;
                    end else begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DISP: if (byte_valid) begin
                    length <= length + 3'd1;
                    if (cnt_q == len_m1_q) begin
                        disp_q    <= acc_sext;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        disp_q <= acc_nxt;
                        cnt_q  <= cnt_q + 2'd1;
                    end
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_modrm_fsm.sv
// Bench for decode_modrm_fsm: fixed vectors, hand sequences for stall/flush/reset, randomized decodes vs a reference model.
module tb_decode_modrm_fsm;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        addr32 = 1'b0;
    logic        start_ready;
    logic        flush = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  mod;
    logic [2:0]  reg_field;
    logic [2:0]  rm;
    logic        reg_operand;
    logic        base_valid;
    logic [2:0]  base;
    logic        index_valid;
    logic [2:0]  index;
    logic [1:0]  scale;
    logic [31:0] disp;
    logic        seg_ss;
    logic [2:0]  length;

    decode_modrm_fsm #(.ENABLE_ADDR32(1'b1), .DISP_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .addr32(addr32),
        .start_ready(start_ready), .flush(flush), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .out_valid(out_valid),
        .out_ready(out_ready), .mod(mod), .reg_field(reg_field), .rm(rm),
        .reg_operand(reg_operand), .base_valid(base_valid), .base(base),
        .index_valid(index_valid), .index(index), .scale(scale), .disp(disp),
        .seg_ss(seg_ss), .length(length)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          a32;
        logic [47:0] bytes;   // first instruction byte in [47:40]
        logic        ro;
        logic [1:0]  mod;
        logic [2:0]  regf;
        logic [2:0]  rm;
        logic        bv;
        logic [2:0]  base;
        logic        iv;
        logic [2:0]  idx;
        logic [1:0]  scale;
        logic [31:0] disp;
        logic        ss;
        logic [2:0]  len;
    } exp_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic exp_t mk(bit a, logic [47:0] v, logic ro, logic [1:0] md, logic [2:0] rf, logic [2:0] r,
                                logic bv, logic [2:0] b, logic iv, logic [2:0] ix, logic [1:0] sc,
                                logic [31:0] d, logic ss, logic [2:0] ln);
        exp_t e;
        e.a32 = a; e.bytes = v; e.ro = ro; e.mod = md; e.regf = rf; e.rm = r;
        e.bv = bv; e.base = b; e.iv = iv; e.idx = ix; e.scale = sc; e.disp = d; e.ss = ss; e.len = ln;
        return e;
    endfunction

    function automatic logic [7:0] bsel(logic [47:0] v, int k);
        return v[47-8*k -: 8];
    endfunction

    // Reference model: decode straight from the addressing-form rules
    function automatic exp_t model(bit a32, logic [47:0] v);
        logic [2:0] bases16 [8] = '{3'd3, 3'd3, 3'd5, 3'd5, 3'd6, 3'd7, 3'd5, 3'd3};
        exp_t e;
        logic [7:0] m;
        logic [7:0] s;
        int p;
        int dsz;
        longint raw;
        e = mk(a32, v, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m = bsel(v, 0);
        e.mod = m[7:6]; e.regf = m[5:3]; e.rm = m[2:0];
        if (e.mod == 2'd3) begin
            e.ro = 1'b1; e.len = 3'd1;
            return e;
        end
        p = 1;
        if (a32) begin
            if (e.rm == 3'd4) begin
                s = bsel(v, 1); p = 2;
                e.scale = s[7:6]; e.idx = s[5:3]; e.iv = (s[5:3] != 3'd4);
                e.base = s[2:0]; e.bv = !(s[2:0] == 3'd5 && e.mod == 2'd0);
            end else begin
                e.base = e.rm; e.bv = !(e.rm == 3'd5 && e.mod == 2'd0);
            end
            dsz = (e.mod == 2'd1) ? 1 : (e.mod == 2'd2) ? 4 : (e.bv ? 0 : 4);
        end else begin
            e.base = bases16[e.rm];
            e.bv   = !(e.rm == 3'd6 && e.mod == 2'd0);
            e.iv   = (e.rm < 3'd4);
            e.idx  = e.rm[0] ? 3'd7 : 3'd6;
            dsz = (e.mod == 2'd1) ? 1 : (e.mod == 2'd2) ? 2 : (e.bv ? 0 : 2);
        end
        raw = 0;
        for (int i = 0; i < dsz; i++) raw += longint'(bsel(v, p + i)) << (8 * i);
        if (dsz > 0 && raw >= (longint'(1) << (8 * dsz - 1))) raw -= longint'(1) << (8 * dsz);
        e.disp = raw[31:0];
        e.ss   = e.bv && (e.base == 3'd4 || e.base == 3'd5);
        e.len  = 3'(p + dsz);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic check_desc(input string nm, input exp_t e);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".reg_operand"}, 32'(reg_operand), 32'(e.ro));
        chk({nm, ".mod"}, 32'(mod), 32'(e.mod));
        chk({nm, ".reg"}, 32'(reg_field), 32'(e.regf));
        chk({nm, ".rm"}, 32'(rm), 32'(e.rm));
        chk({nm, ".base_valid"}, 32'(base_valid), 32'(e.bv));
        if (e.bv) chk({nm, ".base"}, 32'(base), 32'(e.base));
        chk({nm, ".index_valid"}, 32'(index_valid), 32'(e.iv));
        if (e.iv) chk({nm, ".index"}, 32'(index), 32'(e.idx));
        chk({nm, ".scale"}, 32'(scale), 32'(e.scale));
        chk({nm, ".disp"}, disp, e.disp);
        chk({nm, ".seg_ss"}, 32'(seg_ss), 32'(e.ss));
        chk({nm, ".length"}, 32'(length), 32'(e.len));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, ".start_ready"}, 32'(start_ready), 32'd1);
        chk({nm, ".byte_ready"}, 32'(byte_ready), 32'd0);
        chk({nm, ".fields"}, {15'd0, mod, reg_field, rm, reg_operand, base_valid, base, index_valid, index, scale, seg_ss},
            32'd0);
        chk({nm, ".disp"}, disp, 32'd0);
        chk({nm, ".length"}, 32'(length), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after start was accepted
    task automatic start_decode(input bit a32);
        int tries = 0;
        while (!start_ready && tries < 20) begin
            @(negedge clock);
            tries++;
        end
        if (!start_ready) chk("start_ready_timeout", 32'(start_ready), 32'd1);
        start = 1'b1; addr32 = a32;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Offer bytes (with random gaps) until out_valid; checks count and that out_valid follows the final byte
    task automatic feed(input string nm, input logic [47:0] v, input int gap_pct, input logic [2:0] want_len);
        int consumed = 0;
        bit took = 1'b0;
        bit last_took = 1'b0;
        for (int cyc = 0; cyc < 80 && !out_valid; cyc++) begin
            byte_valid = ($urandom_range(99) >= gap_pct);
            byte_data  = (consumed < 6) ? bsel(v, consumed) : 8'h00;
            took = byte_valid && byte_ready;
            @(negedge clock);
            if (took) consumed++;
            last_took = took;
        end
        byte_valid = 1'b0;
        chk({nm, ".done_seen"}, 32'(out_valid), 32'd1);
        chk({nm, ".consumed"}, 32'(consumed), 32'(want_len));
        chk({nm, ".latency"}, 32'(last_took), 32'd1);
    endtask

    task automatic accept(input string nm, input int hold);
        for (int i = 0; i < hold; i++) @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({nm, ".released"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_one(input string nm, input exp_t e, input int gap_pct, input int hold);
        start_decode(e.a32);
        feed(nm, e.bytes, gap_pct, e.len);
        check_desc(nm, e);
        accept(nm, hold);
    endtask

    exp_t tbl [13];
    exp_t e;

    initial begin
        tbl[0]  = mk(1, 48'h44F320_000000, 0, 1, 0, 4, 1, 3, 1, 6, 3, 32'h00000020, 0, 3);
        tbl[1]  = mk(0, 48'h4006_00000000, 0, 1, 0, 0, 1, 3, 1, 6, 0, 32'h00000006, 0, 2);
        tbl[2]  = mk(0, 48'h46FE_00000000, 0, 1, 0, 6, 1, 5, 0, 0, 0, 32'hFFFFFFFE, 1, 2);
        tbl[3]  = mk(0, 48'h063412_000000, 0, 0, 0, 6, 0, 0, 0, 0, 0, 32'h00001234, 0, 3);
        tbl[4]  = mk(1, 48'h0578563412_00, 0, 0, 0, 5, 0, 0, 0, 0, 0, 32'h12345678, 0, 5);
        tbl[5]  = mk(1, 48'h042500100000, 0, 0, 0, 4, 0, 5, 0, 4, 0, 32'h00001000, 0, 6);
        tbl[6]  = mk(1, 48'hC30000000000, 1, 3, 0, 3, 0, 0, 0, 0, 0, 32'h00000000, 0, 1);
        tbl[7]  = mk(0, 48'hC30000000000, 1, 3, 0, 3, 0, 0, 0, 0, 0, 32'h00000000, 0, 1);
        tbl[8]  = mk(1, 48'h846480000000, 0, 2, 0, 4, 1, 4, 0, 4, 1, 32'h00000080, 1, 6);
        tbl[9]  = mk(0, 48'h820080_000000, 0, 2, 0, 2, 1, 5, 1, 6, 0, 32'hFFFF8000, 1, 3);
        tbl[10] = mk(1, 48'h45F0_00000000, 0, 1, 0, 5, 1, 5, 0, 0, 0, 32'hFFFFFFF0, 1, 2);
        tbl[11] = mk(1, 48'h5C2408_000000, 0, 1, 3, 4, 1, 4, 0, 4, 0, 32'h00000008, 1, 3);
        tbl[12] = mk(1, 48'hC00000000000, 1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 1);

        #3;
        check_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_zero("idle");

        for (int i = 0; i < 12; i++) run_one($sformatf("vec%0d", i), tbl[i], 0, i % 3);

        // Gaps inside a 4-byte displacement
        run_one("gaps", tbl[4], 60, 0);

        // Consumer stall, then accept-and-restart in the same cycle
        start_decode(1'b1);
        feed("stall", tbl[0].bytes, 0, tbl[0].len);
        byte_valid = 1'b1; byte_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            chk("stall.byte_ready", 32'(byte_ready), 32'd0);
            check_desc("stall", tbl[0]);
            @(negedge clock);
        end
        byte_valid = 1'b0;
        chk("b2b.start_ready_low", 32'(start_ready), 32'd0);
        out_ready = 1'b1; start = 1'b1; addr32 = 1'b0;
        #1 chk("b2b.start_ready", 32'(start_ready), 32'd1);
        @(negedge clock);
        start = 1'b0; out_ready = 1'b0;
        chk("b2b.modrm_byte_ready", 32'(byte_ready), 32'd1);
        chk("b2b.out_valid", 32'(out_valid), 32'd0);
        feed("b2b", tbl[2].bytes, 0, tbl[2].len);
        check_desc("b2b", tbl[2]);
        accept("b2b", 0);

        // Flush with the third byte on the bus
        start_decode(1'b1);
        byte_valid = 1'b1; byte_data = 8'h44;
        @(negedge clock);
        byte_data = 8'hF3;
        @(negedge clock);
        byte_data = 8'h20; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; byte_valid = 1'b0;
        chk("flush.byte_ready", 32'(byte_ready), 32'd0);
        chk("flush.start_ready", 32'(start_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("flush.out_valid", 32'(out_valid), 32'd0);
            @(negedge clock);
        end
        run_one("after_flush", tbl[12], 0, 0);

        // Asynchronous reset during the displacement
        start_decode(1'b1);
        byte_valid = 1'b1; byte_data = 8'h05;
        @(negedge clock);
        byte_data = 8'h78;
        @(negedge clock);
        byte_valid = 1'b0;
        chk("mid_disp.byte_ready", 32'(byte_ready), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_one("after_reset", tbl[4], 0, 0);

        for (int n = 0; n < 200; n++) begin
            logic [47:0] v;
            bit a;
            v = {$urandom, 16'($urandom)};
            a = 1'($urandom_range(1));
            e = model(a, v);
            run_one($sformatf("rnd%0d", n), e, 30, $urandom_range(2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_modrm_fsm.md
# decode_modrm_fsm

Sequential ModR/M, SIB and displacement decoder for the w80386dx decode unit. After the opcode bytes it takes instruction bytes one per beat from the prefetch queue. It walks ModR/M, then an optional SIB byte, then 0/1/2/4 displacement bytes, and presents one fully decoded effective-address descriptor to the address generator. It succeeds the purely combinational mod/rm field decoder: it adds 32-bit SIB addressing, displacement assembly, default-segment selection, handshakes and flush.

## Interface
Parameters:
- ENABLE_ADDR32, 1, 1 = 32-bit addressing and SIB supported; 0 = `addr32` input is ignored and treated as 0.
- DISP_WIDTH, 32, width of the `disp` output. Legal values are 16 and 32; 32 is required when ENABLE_ADDR32=1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a decode. Accepted only when `start_ready`=1.
- addr32  in  1  effective address size for this instruction (after the 0x67 prefix is applied). Sampled when `start` is accepted.
- start_ready  out  1  decoder can accept `start`.
- flush  in  1  abort the current decode (pipeline flush).
- byte_valid  in  1  `byte_data` is valid.
- byte_data  in  8  next instruction byte.
- byte_ready  out  1  decoder consumes a byte this cycle if `byte_valid`=1.
- out_valid  out  1  descriptor valid, held until accepted.
- out_ready  in  1  consumer accepts the descriptor.
- mod  out  2  ModR/M mod field.
- reg  out  3  ModR/M reg field.
- rm  out  3  ModR/M rm field.
- reg_operand  out  1  mod==11; the operand is a register and no address is formed.
- base_valid  out  1  a base register is used.
- base  out  3  base register in 32-bit numbering (EAX=0 … EDI=7).
- index_valid  out  1  an index register is used.
- index  out  3  index register in 32-bit numbering.
- scale  out  2  index scale as log2 (0..3).
- disp  out  DISP_WIDTH  displacement, sign-extended; 0 when there is no displacement.
- seg_ss  out  1  default segment is SS; otherwise DS.
- length  out  3  number of bytes consumed (1..6).

## Operation
- States are IDLE, MODRM, SIB, DISP and DONE. `start_ready` = (IDLE) or (DONE and `out_ready`).
- IDLE or DONE-with-handshake, on `start`: go to MODRM and latch `addr32`.
- MODRM, on a byte: latch mod, reg and rm, set length=1, then pick the next state:
  - mod==11 → DONE.
  - 32-bit mode, rm==100 → SIB.
  - Otherwise, if a displacement is needed → DISP, else → DONE.
- SIB, on a byte: scale=[7:6] and index=[5:3]; index_valid = (index≠100). base=[2:0]; base_valid = !(base==101 and mod==00). Next state is DISP if a displacement is needed, else DONE.
- DISP: accepts 1, 2 or 4 bytes, little-endian. The byte counter is 2 bits. After the last byte, sign-extend to DISP_WIDTH and go to DONE.
- Displacement size:
  - mod==01 → 1 byte.
  - mod==10 → 2 bytes in 16-bit mode, 4 bytes in 32-bit mode.
  - mod==00 → 2 bytes in 16-bit mode with rm==110; 4 bytes in 32-bit mode with rm==101, or with SIB base==101.
- 16-bit rm map (base/index):
  - 000 = BX/SI, 001 = BX/DI, 010 = BP/SI, 011 = BP/DI.
  - 100 = SI, 101 = DI, 111 = BX, all with no index.
  - 110 = BP, or no base when mod==00.
  - scale is always 0.
- 32-bit, no SIB: base = rm, no index, except rm==101 with mod==00, which has no base.
- seg_ss = base_valid and base ∈ {ESP=4, EBP=5}. With mod==11, all address fields are 0.
- DONE: `out_valid`=1 and the outputs hold stable until `out_ready`. Then go to IDLE, or to MODRM if `start` is accepted in the same cycle.
- `flush` (any state) → IDLE at the next edge. `out_valid` drops at that edge and any byte presented that cycle is not consumed. flush beats start.

## Timing
- Reset: state=IDLE. All outputs are 0 and `start_ready`=1.
- `byte_ready` = 1 in MODRM, SIB and DISP, 0 elsewhere. It is combinational from state only. A byte is consumed on an edge with `byte_valid`&`byte_ready`.
- Each consumed byte advances exactly one step. Stalls (`byte_valid`=0) hold state indefinitely.
- `out_valid` rises on the edge that consumes the last byte, so total latency from start acceptance is length+1 edges.
- Back-to-back operation in DONE with `out_ready`&`start` has no idle bubble.
- Reset asserted mid-decode clears the FSM immediately (asynchronous) and leaves no partial descriptor.

## Test plan
- 32-bit mode, bytes 44 F3 20 → mod=01, reg=0, rm=4, base=3 (EBX), index=6 (ESI), scale=3, disp=0x00000020, seg_ss=0, length=3.
- 16-bit mode, bytes 40 06 → base=3 (BX), index=6 (SI), scale=0, disp=6, length=2. Then 46 FE → base=5 (BP), disp=0xFFFFFFFE, seg_ss=1, length=2.
- Direct addressing:
  - 16-bit, 06 34 12 → base_valid=0, index_valid=0, disp=0x1234, length=3.
  - 32-bit, 05 78 56 34 12 → disp=0x12345678, length=5.
  - 32-bit, 04 25 00 10 00 00 → no base, no index, disp=0x1000, length=6.
- Register form: C3 → reg_operand=1, rm=3, length=1, out_valid one edge after the byte.
- Backpressure:
  - Insert byte_valid gaps mid-displacement → the result is identical.
  - Hold out_ready=0 for 5 cycles → outputs are stable and byte_ready=0.
  - Then out_ready together with start → next decode begins with no idle cycle.
- Flush and reset:
  - flush after byte 2 of 44 F3 20 → IDLE next edge, out_valid never asserts, and the next decode of C0 is correct.
  - reset_n pulsed mid-DISP → all outputs 0 immediately.
